// File: rtl/mdu_arb_pkg.sv
// Shared payload types for the mdu request/result path and a width helper
// used to size requester ids.
package mdu_arb_pkg;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  reg_id;
    } mdu_i_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  reg_id;
    } mdu_o_t;

    typedef struct packed {
        logic [15:0] pc_lo;
        logic [3:0]  rob_id;
    } decode_info_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mdu_tag_fifo.sv
// In-order FIFO of requester ids for requests outstanding inside the mdu.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mdu_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail_q] <= push_data;
    end

    assign head  = mem[head_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mdu_arb.sv
// Round-robin arbiter sharing one mdu between REQ_COUNT requesters; results
// are routed back to their owner through an in-order tag FIFO.
module mdu_arb
    import mdu_arb_pkg::*;
#(
    parameter int unsigned REQ_COUNT = 2,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [REQ_COUNT-1:0] req_valid_i,
    output logic [REQ_COUNT-1:0] req_ready_o,
    input  mdu_i_t               req_i    [REQ_COUNT],
    input  decode_info_t         req_di_i [REQ_COUNT],
    output logic                 mdu_valid_o,
    input  logic                 mdu_ready_i,
    output mdu_i_t               mdu_req_o,
    output decode_info_t         mdu_di_o,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  mdu_o_t               res_i,
    input  decode_info_t         res_di_i,
    output logic [REQ_COUNT-1:0] rsp_valid_o,
    input  logic [REQ_COUNT-1:0] rsp_ready_i,
    output mdu_o_t               rsp_res_o,
    output decode_info_t         rsp_di_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned ID_W = id_width(REQ_COUNT);
    localparam int unsigned CW   = $clog2(TAG_DEPTH) + 1;

    typedef logic [ID_W-1:0] mdu_req_id_t;
    localparam mdu_req_id_t LAST_RST = mdu_req_id_t'(REQ_COUNT - 1);

    mdu_req_id_t   last_q;
    logic          lock_q;
    mdu_req_id_t   lock_id_q;
    logic          err_q;

    logic          grant_exists;
    mdu_req_id_t   grant_id;
    logic          issue;
    logic          pop;
    mdu_req_id_t   head_id;
    logic [CW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;

    // A held lock pins the grant so the offered payload cannot change under
    // the mdu; otherwise scan from the requester after the last grantee.
    always_comb begin
        int          idx;
        mdu_req_id_t cand;
        grant_exists = 1'b0;
        grant_id     = '0;
        idx          = 0;
        cand         = '0;
        if (lock_q) begin
            grant_exists = 1'b1;
            grant_id     = lock_id_q;
        end else begin
            for (int i = 1; i <= int'(REQ_COUNT); i++) begin
                idx = int'(last_q) + i;
                if (idx >= int'(REQ_COUNT)) idx = idx - int'(REQ_COUNT);
                cand = mdu_req_id_t'(idx);
                if (!grant_exists && req_valid_i[cand]) begin
                    grant_exists = 1'b1;
                    grant_id     = cand;
                end
            end
        end
    end

    assign mdu_valid_o = grant_exists & ~tag_full & ~flush;
    assign issue       = mdu_valid_o & mdu_ready_i;

    always_comb begin
        req_ready_o = '0;
        mdu_req_o   = '0;
        mdu_di_o    = '0;
        if (issue) req_ready_o[grant_id] = 1'b1;
        if (grant_exists) begin
            mdu_req_o = req_i[grant_id];
            mdu_di_o  = req_di_i[grant_id];
        end
    end

    // With no tag outstanding a result has no owner: drain it.
    always_comb begin
        rsp_valid_o = '0;
        res_ready_o = 1'b1;
        if (!tag_empty) begin
            res_ready_o = rsp_ready_i[head_id];
            if (!flush) rsp_valid_o[head_id] = res_valid_i;
        end
    end

    assign pop       = ~tag_empty & res_valid_i & res_ready_o;
    assign rsp_res_o = res_i;
    assign rsp_di_o  = res_di_i;
    assign busy_o    = (tag_count != '0);
    assign err_o     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            last_q    <= LAST_RST;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (issue) begin
            last_q <= grant_id;
            lock_q <= 1'b0;
        end else if (mdu_valid_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else if (res_valid_i && tag_empty) err_q <= 1'b1;
    end

    mdu_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (issue),
        .push_data (grant_id),
        .pop       (pop),
        .head      (head_id),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: tb/tb_mdu_arb.sv
// Directed bench for mdu_arb with REQ_COUNT=2, TAG_DEPTH=4.
module tb_mdu_arb;
    import mdu_arb_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    mdu_i_t       req_i    [2];
    decode_info_t req_di_i [2];
    logic         mdu_valid_o;
    logic         mdu_ready_i;
    mdu_i_t       mdu_req_o;
    decode_info_t mdu_di_o;
    logic         res_valid_i;
    logic         res_ready_o;
    mdu_o_t       res_i;
    decode_info_t res_di_i;
    logic [1:0]   rsp_valid_o;
    logic [1:0]   rsp_ready_i;
    mdu_o_t       rsp_res_o;
    decode_info_t rsp_di_o;
    logic         busy_o;
    logic         err_o;

    int n_tests;
    int n_fail;

    mdu_i_t       pay0, pay1;
    decode_info_t di0, di1, rdi;
    mdu_o_t       res_c;

    mdu_arb #(.REQ_COUNT(2), .TAG_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_i       (req_i),
        .req_di_i    (req_di_i),
        .mdu_valid_o (mdu_valid_o),
        .mdu_ready_i (mdu_ready_i),
        .mdu_req_o   (mdu_req_o),
        .mdu_di_o    (mdu_di_o),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_i       (res_i),
        .res_di_i    (res_di_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_res_o   (rsp_res_o),
        .rsp_di_o    (rsp_di_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        req_valid_i = 2'b00;
        mdu_ready_i = 1'b0;
        res_valid_i = 1'b0;
        rsp_ready_i = 2'b11;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pay0  = '{op: 3'd1, rs1: 32'h1111_0000, rs2: 32'h0000_0003, reg_id: 5'd5};
        pay1  = '{op: 3'd4, rs1: 32'h2222_0000, rs2: 32'h0000_0007, reg_id: 5'd9};
        di0   = '{pc_lo: 16'h1000, rob_id: 4'd2};
        di1   = '{pc_lo: 16'h2000, rob_id: 4'd7};
        rdi   = '{pc_lo: 16'hbeef, rob_id: 4'd3};
        res_c = '{result: 32'hcafe_f00d, reg_id: 5'd17};
        req_i[0] = pay0;  req_i[1] = pay1;
        req_di_i[0] = di0; req_di_i[1] = di1;
        res_i = res_c;
        res_di_i = rdi;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Reset / idle state
        check("rst_mdu_valid", 96'(mdu_valid_o), 96'd0);
        check("rst_req_ready", 96'(req_ready_o), 96'd0);
        check("rst_rsp_valid", 96'(rsp_valid_o), 96'd0);
        check("rst_res_ready", 96'(res_ready_o), 96'd1);
        check("rst_busy", 96'(busy_o), 96'd0);
        check("rst_err", 96'(err_o), 96'd0);
        check("rst_payload", 96'(mdu_req_o), 96'd0);

        // Contention with results returning three cycles after issue
        for (int c = 0; c < 7; c++) begin
            req_valid_i = (c < 4) ? 2'b11 : 2'b00;
            mdu_ready_i = 1'b1;
            res_valid_i = (c >= 3);
            rsp_ready_i = 2'b11;
            #1;
            if (c < 4) begin
                check("rr_ready", 96'(req_ready_o), (c % 2 == 0) ? 96'd1 : 96'd2);
                check("rr_payload", 96'(mdu_req_o), (c % 2 == 0) ? 96'(pay0) : 96'(pay1));
            end else begin
                check("rr_idle_valid", 96'(mdu_valid_o), 96'd0);
            end
            if (c == 0) check("rr_di", 96'(mdu_di_o), 96'(di0));
            if (c == 1) check("rr_busy", 96'(busy_o), 96'd1);
            if (c >= 3) begin
                check("rr_rsp_valid", 96'(rsp_valid_o), ((c - 3) % 2 == 0) ? 96'd1 : 96'd2);
                check("rr_res_ready", 96'(res_ready_o), 96'd1);
            end
            if (c == 3) begin
                check("rr_rsp_res", 96'(rsp_res_o), 96'(res_c));
                check("rr_rsp_di", 96'(rsp_di_o), 96'(rdi));
            end
            tick();
        end
        idle();
        #1;
        check("rr_drained_busy", 96'(busy_o), 96'd0);

        // Lock: requester 1 offered while mdu stalls, then requester 0 joins
        for (int c = 0; c < 6; c++) begin
            req_valid_i = (c < 3) ? 2'b10 : 2'b11;
            mdu_ready_i = (c >= 4);
            #1;
            if (c < 4) begin
                check("lock_valid", 96'(mdu_valid_o), 96'd1);
                check("lock_ready", 96'(req_ready_o), 96'd0);
                check("lock_payload", 96'(mdu_req_o), 96'(pay1));
            end else begin
                check("lock_accept", 96'(req_ready_o), (c == 4) ? 96'd2 : 96'd1);
            end
            tick();
        end
        idle();
        for (int c = 0; c < 2; c++) begin
            res_valid_i = 1'b1;
            #1;
            check("lock_rsp_order", 96'(rsp_valid_o), (c == 0) ? 96'd2 : 96'd1);
            tick();
        end
        idle();
        #1;
        check("lock_drained_busy", 96'(busy_o), 96'd0);

        // Fill the tag FIFO: fifth request waits for a pop, issues after it
        for (int c = 0; c < 7; c++) begin
            req_valid_i = 2'b01;
            mdu_ready_i = 1'b1;
            res_valid_i = (c == 5);
            #1;
            if (c < 4 || c == 6) begin
                check("full_accept", 96'(req_ready_o), 96'd1);
            end else begin
                check("full_blocked_valid", 96'(mdu_valid_o), 96'd0);
                check("full_blocked_ready", 96'(req_ready_o), 96'd0);
            end
            if (c == 5) begin
                check("full_pop_rsp", 96'(rsp_valid_o), 96'd1);
                check("full_pop_ready", 96'(res_ready_o), 96'd1);
            end
            tick();
        end
        idle();

        // Owner back-pressure holds the head tag
        res_valid_i = 1'b1;
        rsp_ready_i = 2'b00;
        #1;
        check("bp_res_ready", 96'(res_ready_o), 96'd0);
        check("bp_rsp_valid", 96'(rsp_valid_o), 96'd1);
        tick();
        rsp_ready_i = 2'b10;
        #1;
        check("bp_other_ready", 96'(res_ready_o), 96'd0);
        tick();
        check("bp_busy_held", 96'(busy_o), 96'd1);
        rsp_ready_i = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_pop_ready", 96'(res_ready_o), 96'd1);
            tick();
            check("bp_busy_count", 96'(busy_o), (c < 3) ? 96'd1 : 96'd0);
        end
        idle();

        // Flush with three tags outstanding, then a stray result
        for (int c = 0; c < 3; c++) begin
            req_valid_i = 2'b10;
            mdu_ready_i = 1'b1;
            #1;
            check("fl_issue", 96'(req_ready_o), 96'd2);
            tick();
        end
        idle();
        #1;
        check("fl_busy_before", 96'(busy_o), 96'd1);
        flush       = 1'b1;
        req_valid_i = 2'b11;
        mdu_ready_i = 1'b1;
        res_valid_i = 1'b1;
        #1;
        check("fl_mdu_valid", 96'(mdu_valid_o), 96'd0);
        check("fl_rsp_valid", 96'(rsp_valid_o), 96'd0);
        check("fl_req_ready", 96'(req_ready_o), 96'd0);
        tick();
        idle();
        #1;
        check("fl_busy_after", 96'(busy_o), 96'd0);
        check("fl_err_clean", 96'(err_o), 96'd0);
        res_valid_i = 1'b1;
        #1;
        check("stray_rsp_valid", 96'(rsp_valid_o), 96'd0);
        check("stray_res_ready", 96'(res_ready_o), 96'd1);
        tick();
        idle();
        #1;
        check("stray_err", 96'(err_o), 96'd1);
        flush = 1'b1;
        tick();
        idle();
        #1;
        check("err_sticky_flush", 96'(err_o), 96'd1);
        req_valid_i = 2'b11;
        mdu_ready_i = 1'b1;
        #1;
        check("fl_prio_reset", 96'(req_ready_o), 96'd1);
        tick();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_arb.md
# mdu_arb

Round-robin arbiter that shares one `mdu` instance between `REQ_COUNT` issue-side requesters, e.g. the integer issue queues of both pipes. It sits between the requesters' execute stage and the `mdu` valid/ready ports. An in-order tag FIFO records the grantee of every accepted request, and each `mdu` result is routed back to that requester. Request and result paths are zero-latency pass-through; only arbitration state and tags are registered.

## Interface
- `REQ_COUNT`, 2: number of requesters (2..4).
- `TAG_DEPTH`, 4: maximum requests outstanding inside `mdu` (power of 2).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  pipeline flush; same cycle `mdu` is flushed.
- `req_valid_i`  in  `[REQ_COUNT]`  request valid per requester.
- `req_ready_o`  out  `[REQ_COUNT]`  request accepted (one-hot or zero).
- `req_i`  in  `mdu_i_t [REQ_COUNT]`  operands/op/reg_id.
- `req_di_i`  in  `decode_info_t [REQ_COUNT]`  decode info.
- `mdu_valid_o`  out  1  to `mdu` `valid_i`.
- `mdu_ready_i`  in  1  from `mdu` `ready_o`.
- `mdu_req_o`  out  `mdu_i_t`  granted payload.
- `mdu_di_o`  out  `decode_info_t`  granted decode info.
- `res_valid_i`  in  1  from `mdu` `valid_o`.
- `res_ready_o`  out  1  to `mdu` `ready_i`.
- `res_i`  in  `mdu_o_t`  result.
- `res_di_i`  in  `decode_info_t`  result decode info.
- `rsp_valid_o`  out  `[REQ_COUNT]`  result valid, one-hot to owner.
- `rsp_ready_i`  in  `[REQ_COUNT]`  owner FIFO ready.
- `rsp_res_o`  out  `mdu_o_t`  result, broadcast.
- `rsp_di_o`  out  `decode_info_t`  decode info, broadcast.
- `busy_o`  out  1  tag count ≠ 0 (registered).
- `err_o`  out  1  sticky: result arrived with tag FIFO empty.

## Operation
- State:
  - `last_q`: last granted id; reset value `REQ_COUNT-1`, so requester 0 has first priority.
  - `lock_q` / `lock_id_q`: a grant offered but not yet accepted.
  - Tag FIFO: head, tail and count.
  - `err_q`.
- Grant selection:
  - If `lock_q`, grant is `lock_id_q`.
  - Otherwise grant is the first valid requester scanning from `last_q+1` with wrap-around.
  - Grant never depends on `mdu_ready_i`.
- `mdu_valid_o = grant_exists & (count_q != TAG_DEPTH)`. Payload is muxed from the granted requester, or zero when no grant.
- `req_ready_o[g] = mdu_valid_o & mdu_ready_i`, where g is the grantee.
- Issue handshake: push g into the tag FIFO, set `last_q <= g`, clear `lock_q`.
- If `mdu_valid_o & !mdu_ready_i`, set `lock_q <= 1` and `lock_id_q <= g`. The grant is held until it is accepted.
  - Requesters must hold valid and payload stable while not ready. Dropping valid while locked is a protocol violation.
- Full FIFO (`count_q == TAG_DEPTH`): no issue, even if a pop happens the same cycle.
- Result routing, tag FIFO non-empty, head tag h:
  - `rsp_valid_o[h] = res_valid_i`.
  - `res_ready_o = rsp_ready_i[h]`.
  - Pop on `res_valid_i & res_ready_o`.
- Result routing, tag FIFO empty:
  - `rsp_valid_o = 0` and `res_ready_o = 1` (drain).
  - `res_valid_i` sets `err_q`.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Flush or reset:
  - Next cycle: count, head and tail are 0, `lock_q` is 0, `last_q` is `REQ_COUNT-1`.
  - During the flush cycle: `mdu_valid_o = 0` and `rsp_valid_o = 0`.
  - Flush does not clear `err_q`; only reset does.
- Reset values of outputs with inputs idle: all valids 0, `req_ready_o` 0, `res_ready_o` 1, `busy_o` 0, `err_o` 0, payloads 0.

## Timing
- Request to `mdu` and result to requester are combinational, with 0 added latency.
- A tag pushed in cycle N is the FIFO head at the earliest in N+1. `mdu` latency is ≥1 cycle, so a result never matches a same-cycle push.
- Back-to-back issue is supported at one grant per cycle.
- Fairness: under continuous contention, grants alternate strictly.
- `busy_o` and `err_o` are registered. All other outputs are combinational from state and inputs.

## Structure
- `a_defines.svh` owns:
  - `mdu_i_t`, `mdu_o_t`, `decode_info_t` (existing).
  - New `mdu_req_id_t` (`$clog2(REQ_COUNT)` bits).
- Sub-module `mdu_tag_fifo`: parameters `DEPTH` and `WIDTH`; provides push/pop, head, count and full/empty outputs, plus synchronous clear on flush.
- Grant logic (round-robin rotate plus lock) stays inline in `mdu_arb`.

## Test plan
- Reset, then idle: all valids 0, `res_ready_o` 1, `busy_o` 0.
- Both requesters valid every cycle, `mdu_ready_i` = 1: grants go 0,1,0,1.
  - `mdu` results come back 3 cycles later.
  - `rsp_valid_o` pattern is 01,10,01,10 (one-hot, requester 0 first).
- Requester 1 alone, `mdu_ready_i` = 0 for 3 cycles, then requester 0 also raises valid: grant stays locked on 1 until accepted, then goes to 0.
- Five requests issued with no results (`TAG_DEPTH` 4): the fifth is not accepted until the first result pops, and it issues the cycle after that pop.
- Owner `rsp_ready_i` = 0 with result valid: `res_ready_o` = 0 and the tag is held. Raising `rsp_ready_i` pops the tag and the count decrements.
- `flush` with 3 tags outstanding: next cycle count is 0 and `busy_o` 0. A stray `res_valid_i` then sets `err_o` = 1 and is drained.
